// File: rtl/cp0_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_unit_if
//  Description : M-stage pipeline <-> CP0 signal bundle (exception, mfc0/mtc0, eret)
//  Revision    : 1.0 - initial release
// ============================================================================
interface cp0_unit_if;
    logic [31:0] pc_m;
    logic [4:0]  exccode_m;
    logic        bd_m;
    logic [5:0]  hwint;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        eret_m;
    logic [31:0] rdata;
    logic [31:0] epc_out;
    logic        exc_req;
    logic [31:0] handler_pc;

    modport master (
        output pc_m, exccode_m, bd_m, hwint, we, addr, wdata, eret_m,
        input  rdata, epc_out, exc_req, handler_pc
    );

    modport slave (
        input  pc_m, exccode_m, bd_m, hwint, we, addr, wdata, eret_m,
        output rdata, epc_out, exc_req, handler_pc
    );
endinterface
`default_nettype wire

// File: rtl/cp0_unit.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_unit
//  Description : Coprocessor 0 - SR/Cause/EPC/PRId, interrupt vs exception arbitration
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0_unit #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL   = 32'h2018_0601
) (
    input  wire logic clk,
    input  wire logic reset_n,
    cp0_unit_if.slave bus
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [29:0] epc;

    logic        int_req;
    logic        sync_req;
    logic        take_exc;
    logic [31:0] victim_pc;

    assign int_req   = (|(bus.hwint & im)) & ie & ~exl;
    assign sync_req  = (bus.exccode_m != 5'd0) & ~exl;
    assign take_exc  = int_req | sync_req;
    assign victim_pc = bus.bd_m ? (bus.pc_m - 32'd4) : bus.pc_m;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= '0;
            exc_code <= '0;
            epc      <= '0;
        end else begin
            ip <= bus.hwint;
            if (take_exc) begin
                exl      <= 1'b1;
                bd       <= bus.bd_m;
                exc_code <= int_req ? 5'd0 : bus.exccode_m;
                epc      <= victim_pc[31:2];
            end else begin
                // mtc0 lands first; eret then overrides EXL alone
                if (bus.we) begin
                    case (bus.addr)
                        ADDR_SR: begin
                            im  <= bus.wdata[15:10];
                            exl <= bus.wdata[1];
                            ie  <= bus.wdata[0];
                        end
                        ADDR_EPC: epc <= bus.wdata[31:2];
                        default:  ;
                    endcase
                end
                if (bus.eret_m) begin
                    exl <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        bus.rdata = 32'd0;
        case (bus.addr)
            ADDR_SR:    bus.rdata = {16'd0, im, 8'd0, exl, ie};
            ADDR_CAUSE: bus.rdata = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};
            ADDR_EPC:   bus.rdata = {epc, 2'b00};
            ADDR_PRID:  bus.rdata = PRID_VAL;
            default:    bus.rdata = 32'd0;
        endcase
    end

    assign bus.epc_out    = {epc, 2'b00};
    assign bus.exc_req    = take_exc;
    assign bus.handler_pc = HANDLER_PC;

endmodule
`default_nettype wire
